buffer_port_sequencer: RTL

//  Serial (mode-0) initiator for the N_BUF-bank memory buffer. Moves a block of words

---
 rtl/buffer_port_sequencer.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/buffer_port_sequencer.sv
`default_nettype none
//----------------------------------------------------------------------------
// Module  : buffer_port_sequencer
// Purpose : Mode-0 serial initiator moving a word block between a valid/ready
//           stream and the banked memory buffer, one bank per access.
//           Optional BUF_SEQ_CSUM_EN adds a running word checksum port.
// Rev     : 1.0
//----------------------------------------------------------------------------
module buffer_port_sequencer #(
    parameter int N_BUF    = 6,
    parameter int ADDR_RAM = 8,
    parameter int WID      = 16,
    parameter int LEN_W    = 12,
    localparam int BSEL_W  = $clog2(N_BUF + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_dir,
    input  logic [BSEL_W-1:0]   cmd_bank,
    input  logic [ADDR_RAM-1:0] cmd_addr,
    input  logic [LEN_W-1:0]    cmd_len,
    input  logic [WID-1:0]      in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [WID-1:0]      out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                mode,
    output logic [BSEL_W-1:0]   m0_w_en,
    output logic [ADDR_RAM-1:0] m0_w_addr,
    output logic [WID-1:0]      m0_w_data,
    output logic [BSEL_W-1:0]   m0_r_en,
    output logic [ADDR_RAM-1:0] m0_r_addr,
    input  logic [WID-1:0]      m0_r_data,
    output logic                busy,
    output logic                done,
`ifdef BUF_SEQ_CSUM_EN
    output logic [WID-1:0]      csum,
    output logic                err
`else
    output logic                err
`endif
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_WR     = 3'd1;
    localparam logic [2:0] S_RD_ISS = 3'd2;
    localparam logic [2:0] S_RD_CAP = 3'd3;
    localparam logic [2:0] S_RD_OUT = 3'd4;
    localparam logic [2:0] S_FIN    = 3'd5;

    localparam logic [BSEL_W-1:0] c_NO_BANK   = BSEL_W'(N_BUF);
    localparam logic [BSEL_W-1:0] c_LAST_BANK = BSEL_W'(N_BUF - 1);

    logic [2:0]          r_state;
    logic [2:0]          w_state_nxt;
    logic [BSEL_W-1:0]   r_bank;
    logic [ADDR_RAM-1:0] r_addr;
    logic [LEN_W-1:0]    r_left;
    logic                r_err;
    logic [BSEL_W-1:0]   r_w_en;
    logic [ADDR_RAM-1:0] r_w_addr;
    logic [WID-1:0]      r_w_data;
    logic [BSEL_W-1:0]   r_r_en;
    logic [ADDR_RAM-1:0] r_r_addr;
    logic [WID-1:0]      r_out_data;

    logic                w_accept;
    logic                w_cmd_bad;
    logic                w_in_hs;
    logic                w_cap;
    logic                w_rd_bus;
    logic [BSEL_W-1:0]   w_bank_next;
    logic [ADDR_RAM-1:0] w_addr_next;
    logic [BSEL_W-1:0]   w_acc_bank;
    logic [ADDR_RAM-1:0] w_acc_addr;

    assign w_accept    = (r_state == S_IDLE) && cmd_valid;
    assign w_cmd_bad   = (cmd_bank >= c_NO_BANK);
    assign w_in_hs     = (r_state == S_WR) && in_valid;
    assign w_cap       = (r_state == S_RD_CAP);
    assign w_rd_bus    = (w_state_nxt == S_RD_ISS) || (w_state_nxt == S_RD_CAP);
    // Address steps only when the bank index wraps back to bank 0.
    assign w_bank_next = (r_bank == c_LAST_BANK) ? '0 : r_bank + BSEL_W'(1);
    assign w_addr_next = (r_bank == c_LAST_BANK) ? r_addr + ADDR_RAM'(1) : r_addr;
    assign w_acc_bank  = (r_state == S_IDLE) ? cmd_bank : r_bank;
    assign w_acc_addr  = (r_state == S_IDLE) ? cmd_addr : r_addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (cmd_valid) begin
                    if (w_cmd_bad || (cmd_len == '0)) w_state_nxt = S_FIN;
                    else if (cmd_dir)                 w_state_nxt = S_RD_ISS;
                    else                              w_state_nxt = S_WR;
                end
            end
            S_WR:     if (in_valid && (r_left == LEN_W'(1))) w_state_nxt = S_FIN;
            S_RD_ISS: w_state_nxt = S_RD_CAP;
            S_RD_CAP: w_state_nxt = S_RD_OUT;
            S_RD_OUT: if (out_ready) w_state_nxt = (r_left == '0) ? S_FIN : S_RD_ISS;
            S_FIN:    w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = 1'b0;
        busy      = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        case (r_state)
            S_IDLE:   cmd_ready = 1'b1;
            S_WR:     begin busy = 1'b1; in_ready = 1'b1; end
            S_RD_ISS: busy = 1'b1;
            S_RD_CAP: busy = 1'b1;
            S_RD_OUT: begin busy = 1'b1; out_valid = 1'b1; end
            S_FIN:    begin done = 1'b1; err = r_err; end
            default:  cmd_ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bank     <= '0;
            r_addr     <= '0;
            r_left     <= '0;
            r_err      <= 1'b0;
            r_w_en     <= c_NO_BANK;
            r_w_addr   <= '0;
            r_w_data   <= '0;
            r_r_en     <= c_NO_BANK;
            r_r_addr   <= '0;
            r_out_data <= '0;
        end else begin
            if (w_accept) begin
                r_bank <= cmd_bank;
                r_addr <= cmd_addr;
                r_left <= cmd_len;
                r_err  <= w_cmd_bad;
            end else if (w_in_hs || w_cap) begin
                r_bank <= w_bank_next;
                r_addr <= w_addr_next;
                r_left <= r_left - LEN_W'(1);
            end
            r_w_en <= w_in_hs ? r_bank : c_NO_BANK;
            if (w_in_hs) begin
                r_w_addr <= r_addr;
                r_w_data <= in_data;
            end
            // Index stays on the bank through capture so the buffer mux keeps selecting it.
            if (w_rd_bus) begin
                r_r_en   <= w_acc_bank;
                r_r_addr <= w_acc_addr;
            end else begin
                r_r_en   <= c_NO_BANK;
            end
            if (w_cap) r_out_data <= m0_r_data;
        end
    end

`ifdef BUF_SEQ_CSUM_EN
    logic [WID-1:0] r_csum;

    always_ff @(posedge clk) begin
        if (rst)            r_csum <= '0;
        else if (w_accept)  r_csum <= '0;
        else if (w_in_hs)   r_csum <= r_csum + in_data;
        else if (w_cap)     r_csum <= r_csum + m0_r_data;
    end

    assign csum = r_csum;
`endif

    assign mode      = 1'b0;
    assign m0_w_en   = r_w_en;
    assign m0_w_addr = r_w_addr;
    assign m0_w_data = r_w_data;
    assign m0_r_en   = r_r_en;
    assign m0_r_addr = r_r_addr;
    assign out_data  = r_out_data;

endmodule
`default_nettype wire
